traffic_phase_sched: RTL and testbench

- Timed phase scheduler for a two-road intersection (north-south and east-west).
- Drives one 3-bit lamp per road using the team lamp encoding, plus a pedestrian walk signal.
- Phase durations are counted in ticks of an external timebase strobe.
- Serves latched pedestrian requests and an emergency all-red override; sits between the timebase divider and the lamp drivers.

---
 rtl/traffic_phase_sched_pkg.sv | 25 ++
 rtl/traffic_phase_sched_phase_timer.sv | 22 ++
 rtl/traffic_phase_sched.sv | 83 ++++++++
 tb/tb_traffic_phase_sched.sv | 175 +++++++++++++++++
 4 files changed

// File: rtl/traffic_phase_sched_pkg.sv
// traffic_phase_sched_pkg: lamp encoding, phase codes and default durations shared by the scheduler.
package traffic_phase_sched_pkg;
    localparam logic [2:0] RED    = 3'b100;
    localparam logic [2:0] YELLOW = 3'b010;
    localparam logic [2:0] GREEN  = 3'b001;
    typedef enum logic [2:0] {
        NS_G = 3'd0,
        NS_Y = 3'd1,
        AR_N = 3'd2,
        EW_G = 3'd3,
        EW_Y = 3'd4,
        AR_E = 3'd5,
        WALK = 3'd6,
        EMRG = 3'd7
    } phase_t;
    localparam int DEF_GREEN_TICKS  = 8;
    localparam int DEF_YELLOW_TICKS = 2;
    localparam int DEF_ALLRED_TICKS = 1;
    localparam int DEF_WALK_TICKS   = 4;
    localparam int DEF_CNT_W        = 8;
    // a zero duration behaves as one tick
    function automatic int dur_m1(int d);
        return (d < 1) ? 0 : d - 1;
    endfunction
endpackage

// File: rtl/traffic_phase_sched_phase_timer.sv
// traffic_phase_sched_phase_timer: loadable down-counter advancing on tick_en, with a zero flag.
module traffic_phase_sched_phase_timer #(
    parameter int               CNT_W   = 8,
    parameter logic [CNT_W-1:0] RST_VAL = '0
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             tick_en,
    input  logic             load,
    input  logic [CNT_W-1:0] load_val,
    output logic             zero
);
    logic [CNT_W-1:0] cnt;
    assign zero = (cnt == '0);
    always_ff @(posedge clk or negedge reset_n)
        if (!reset_n)
            cnt <= RST_VAL;
        else if (load)
            cnt <= load_val;
        else if (tick_en && !zero)
            cnt <= cnt - 1'b1;
endmodule

// File: rtl/traffic_phase_sched.sv
// traffic_phase_sched: timed two-road phase scheduler with pedestrian service and emergency all-red.
module traffic_phase_sched
    import traffic_phase_sched_pkg::*;
#(
    parameter int GREEN_TICKS  = DEF_GREEN_TICKS,
    parameter int YELLOW_TICKS = DEF_YELLOW_TICKS,
    parameter int ALLRED_TICKS = DEF_ALLRED_TICKS,
    parameter int WALK_TICKS   = DEF_WALK_TICKS,
    parameter int CNT_W        = DEF_CNT_W
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       tick_en,
    input  logic       ped_req,
    input  logic       emerg,
    output logic [2:0] ns_light,
    output logic [2:0] ew_light,
    output logic       walk,
    output logic       ped_ack,
    output logic [2:0] phase
);
    phase_t           state, state_n;
    logic             zero, timed, grant, ped_pending, next_dir;
    logic [CNT_W-1:0] load_val;
    int               dur;

    assign timed = zero && tick_en;
    assign grant = (state_n == WALK) && (state != WALK);

    always_comb begin
        state_n = state;
        unique case (state)
            NS_G: state_n = (emerg || timed) ? NS_Y : NS_G;
            NS_Y: state_n = timed ? AR_N : NS_Y;
            AR_N: state_n = !timed ? AR_N : emerg ? EMRG : ped_pending ? WALK : EW_G;
            EW_G: state_n = (emerg || timed) ? EW_Y : EW_G;
            EW_Y: state_n = timed ? AR_E : EW_Y;
            AR_E: state_n = !timed ? AR_E : emerg ? EMRG : ped_pending ? WALK : NS_G;
            WALK: state_n = emerg ? EMRG : !timed ? WALK : next_dir ? EW_G : NS_G;
            EMRG: state_n = emerg ? EMRG : AR_E;
            default: state_n = AR_E;
        endcase
    end

    always_comb begin
        dur = (state_n == NS_G || state_n == EW_G) ? GREEN_TICKS :
              (state_n == NS_Y || state_n == EW_Y) ? YELLOW_TICKS :
              (state_n == WALK) ? WALK_TICKS : ALLRED_TICKS;
        load_val = CNT_W'(dur_m1(dur));
    end

    traffic_phase_sched_phase_timer #(
        .CNT_W  (CNT_W),
        .RST_VAL(CNT_W'(dur_m1(ALLRED_TICKS)))
    ) u_timer (
        .clk     (clk),
        .reset_n (reset_n),
        .tick_en (tick_en),
        .load    (state_n != state),
        .load_val(load_val),
        .zero    (zero)
    );

    always_ff @(posedge clk or negedge reset_n)
        if (!reset_n) begin
            state       <= AR_E;
            ped_pending <= 1'b0;
            ped_ack     <= 1'b0;
            next_dir    <= 1'b0;
        end else begin
            state       <= state_n;
            ped_ack     <= grant;
            ped_pending <= grant ? 1'b0 : (ped_req && state != WALK) ? 1'b1 : ped_pending;
            // remember which green the walk displaced: 1 = east-west
            if (grant)
                next_dir <= (state == AR_N);
        end

    assign ns_light = (state == NS_G) ? GREEN : (state == NS_Y) ? YELLOW : RED;
    assign ew_light = (state == EW_G) ? GREEN : (state == EW_Y) ? YELLOW : RED;
    assign walk     = (state == WALK);
    assign phase    = state;
endmodule

// File: tb/tb_traffic_phase_sched.sv
// tb_traffic_phase_sched: directed vectors with hand-computed expectations for traffic_phase_sched.
module tb_traffic_phase_sched;
    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic       tick_en = 1'b0;
    logic       ped_req = 1'b0;
    logic       emerg = 1'b0;
    logic [2:0] ns_light, ew_light, phase;
    logic       walk, ped_ack;
    int         checks = 0;
    int         errors = 0;
    int         seq_exp[23] = '{0,0,0,0,0,0,0,0,1,1,2,3,3,3,3,3,3,3,3,4,4,5,0};

    traffic_phase_sched dut (
        .clk     (clk),
        .reset_n (reset_n),
        .tick_en (tick_en),
        .ped_req (ped_req),
        .emerg   (emerg),
        .ns_light(ns_light),
        .ew_light(ew_light),
        .walk    (walk),
        .ped_ack (ped_ack),
        .phase   (phase)
    );

    always #5 clk = ~clk;

    task automatic check(string tag, int obs, int exp_v);
        checks++;
        if (obs != exp_v) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp_v);
        end
    endtask

    task automatic step(int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        step(3);
        check("rst_phase", phase, 5);
        check("rst_ns", ns_light, 4);
        check("rst_ew", ew_light, 4);
        check("rst_walk", walk, 0);
        check("rst_ack", ped_ack, 0);
        reset_n = 1'b1;
        tick_en = 1'b1;
        // free-running cycle, edges 1..23
        for (int i = 0; i < 23; i++) begin
            step(1);
            check($sformatf("seq%0d", i + 1), phase, seq_exp[i]);
            if (i == 0) check("seq_ns_green", ns_light, 1);
            if (i == 0) check("seq_ew_red", ew_light, 4);
            if (i == 8) check("seq_ns_yellow", ns_light, 2);
            if (i == 11) check("seq_ew_green", ew_light, 1);
            if (i == 19) check("seq_ew_yellow", ew_light, 2);
        end
        // pedestrian pulse during NS_G (edge 23 onward)
        ped_req = 1'b1;
        step(1);
        ped_req = 1'b0;
        step(9);
        check("ped_arn", phase, 2);
        check("ped_arn_ack", ped_ack, 0);
        step(1);
        check("ped_walk", phase, 6);
        check("ped_walk_lamp", walk, 1);
        check("ped_ack_pulse", ped_ack, 1);
        check("ped_walk_ns", ns_light, 4);
        check("ped_walk_ew", ew_light, 4);
        step(1);
        check("ped_ack_drop", ped_ack, 0);
        check("ped_walk2", walk, 1);
        step(2);
        check("ped_walk4", phase, 6);
        step(1);
        check("ped_to_ewg", phase, 3);
        // request held through WALK gives one service only
        ped_req = 1'b1;
        step(10);
        check("hold_are", phase, 5);
        step(1);
        check("hold_walk", phase, 6);
        check("hold_ack", ped_ack, 1);
        step(3);
        ped_req = 1'b0;
        step(1);
        check("hold_to_nsg", phase, 0);
        step(11);
        check("hold_no_rewalk", phase, 3);
        ped_req = 1'b1;
        step(1);
        ped_req = 1'b0;
        step(9);
        check("late_are", phase, 5);
        step(1);
        check("late_walk", phase, 6);
        check("late_ack", ped_ack, 1);
        step(4);
        check("late_to_nsg", phase, 0);
        // emergency on third cycle of EW_G
        step(13);
        check("em_ewg", phase, 3);
        emerg = 1'b1;
        step(1);
        check("em_ewy", phase, 4);
        check("em_ewy_lamp", ew_light, 2);
        step(2);
        check("em_are", phase, 5);
        step(1);
        check("em_emrg", phase, 7);
        check("em_ns", ns_light, 4);
        check("em_ew", ew_light, 4);
        step(9);
        check("em_held", phase, 7);
        emerg = 1'b0;
        step(1);
        check("em_exit_are", phase, 5);
        step(1);
        check("em_exit_nsg", phase, 0);
        // emergency during WALK, request latched in EMRG
        ped_req = 1'b1;
        step(1);
        ped_req = 1'b0;
        step(10);
        check("ew_walk", phase, 6);
        emerg = 1'b1;
        step(1);
        check("ew_emrg", phase, 7);
        check("ew_walk_off", walk, 0);
        ped_req = 1'b1;
        step(1);
        ped_req = 1'b0;
        step(2);
        emerg = 1'b0;
        step(1);
        check("ew_are", phase, 5);
        check("ew_are_ack", ped_ack, 0);
        step(1);
        check("ew_walk2", phase, 6);
        check("ew_ack", ped_ack, 1);
        step(4);
        check("ew_to_nsg", phase, 0);
        // slow timebase, then reset mid-NS_Y
        reset_n = 1'b0;
        tick_en = 1'b0;
        step(1);
        reset_n = 1'b1;
        for (int i = 0; i < 35; i++) begin
            tick_en = (i % 4 == 0);
            ped_req = (i == 5);
            step(1);
            if (i == 31) check("slow_nsg_end", phase, 0);
            if (i == 32) check("slow_nsy", phase, 1);
        end
        tick_en = 1'b0;
        #2;
        reset_n = 1'b0;
        #1;
        check("mid_rst_phase", phase, 5);
        check("mid_rst_ns", ns_light, 4);
        check("mid_rst_ew", ew_light, 4);
        step(1);
        reset_n = 1'b1;
        tick_en = 1'b1;
        step(12);
        check("mid_rst_no_walk", phase, 3);
        check("mid_rst_ack", ped_ack, 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
